// File: rtl/speed_limit_sequencer.sv
// Speed-limit sequencer: accepts clamped limit requests and ramps the effective
// limit toward the target in bounded steps, with an emergency override to zero.
module speed_limit_sequencer #(
    parameter int STEP          = 5,
    parameter int RAMP_CYCLES   = 10,
    parameter int MIN_LIMIT     = 0,
    parameter int MAX_LIMIT     = 200,
    parameter int DEFAULT_LIMIT = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] req_limit,
    output logic       req_ready,
    input  logic       emergency,
    output logic [7:0] speed_limit,
    output logic       ramping,
    output logic       clamped
);

    localparam int TW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        EMERG     = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_speed;
    logic [7:0]      r_target;
    logic [TW-1:0]   r_timer;
    logic            r_clamped;

    logic            w_accept;
    logic [7:0]      w_tgt;
    logic            w_tgtClamped;
    logic [8:0]      w_upWide;
    logic [7:0]      w_upStep;
    logic signed [9:0] w_downWide;
    logic [7:0]      w_downStep;
    logic            w_stepDue;

    assign req_ready   = (r_state != EMERG) && !emergency;
    assign w_accept    = req_valid && req_ready;
    assign speed_limit = r_speed;
    assign ramping     = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
    assign clamped     = r_clamped;
    assign w_stepDue   = (r_timer == TW'(RAMP_CYCLES - 1));

    // Signed 10-bit compares keep the clamp well-behaved even when MIN_LIMIT is 0.
    always_comb begin
        w_tgt        = req_limit;
        w_tgtClamped = 1'b0;
        if ($signed({2'b00, req_limit}) < $signed(10'(MIN_LIMIT))) begin
            w_tgt        = 8'(MIN_LIMIT);
            w_tgtClamped = 1'b1;
        end else if ($signed({2'b00, req_limit}) > $signed(10'(MAX_LIMIT))) begin
            w_tgt        = 8'(MAX_LIMIT);
            w_tgtClamped = 1'b1;
        end
    end

    // Widened arithmetic so a step can neither wrap past 255 nor underflow past 0.
    always_comb begin
        w_upWide   = {1'b0, r_speed} + 9'(STEP);
        w_upStep   = (w_upWide > {1'b0, r_target}) ? r_target : w_upWide[7:0];
        w_downWide = $signed({2'b00, r_speed}) - $signed(10'(STEP));
        w_downStep = (w_downWide < $signed({2'b00, r_target})) ? r_target : w_downWide[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_speed   <= 8'(DEFAULT_LIMIT);
            r_target  <= 8'(DEFAULT_LIMIT);
            r_timer   <= '0;
            r_clamped <= 1'b0;
        end else begin
            r_clamped <= 1'b0;
            if (emergency) begin
                r_state <= EMERG;
                r_speed <= 8'd0;
                r_timer <= '0;
            end else if (r_state == EMERG) begin
                r_state <= (r_target != 8'd0) ? RAMP_UP : IDLE;
                r_timer <= '0;
            end else if (w_accept) begin
                r_target  <= w_tgt;
                r_timer   <= '0;
                r_clamped <= w_tgtClamped;
                if (w_tgt > r_speed)
                    r_state <= RAMP_UP;
                else if (w_tgt < r_speed)
                    r_state <= RAMP_DOWN;
                else
                    r_state <= IDLE;
            end else begin
                case (r_state)
                    RAMP_UP: begin
                        if (w_stepDue) begin
                            r_speed <= w_upStep;
                            r_timer <= '0;
                            if (w_upStep == r_target)
                                r_state <= IDLE;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    RAMP_DOWN: begin
                        if (w_stepDue) begin
                            r_speed <= w_downStep;
                            r_timer <= '0;
                            if (w_downStep == r_target)
                                r_state <= IDLE;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule
